// File: rtl/input_conditioner.sv
// Debounces two 9-bit joystick ports, turns coin presses into frame-timed pulses and, with
// INPUT_AUTOFIRE_EN defined, adds frame-based autofire. All outputs are registered and active-low.
`timescale 1ns/1ps
module input_conditioner #(
   parameter int DEB_CYCLES  = 1024,
   parameter int COIN_FRAMES = 4,
   parameter int GAP_FRAMES  = 4,
   parameter int AF_FRAMES   = 3
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       vblank,
   input  logic [8:0] joy_p1,
   input  logic [8:0] joy_p2,
   input  logic       autofire_en,
   output logic [1:0] o_coin,
   output logic [1:0] o_fire,
   output logic [1:0] o_bomb,
   output logic [1:0] o_select,
   output logic [1:0] o_up,
   output logic [1:0] o_down,
   output logic [1:0] o_left,
   output logic [1:0] o_right
);

   localparam int DW   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam int FMAX = (COIN_FRAMES > GAP_FRAMES) ? COIN_FRAMES : GAP_FRAMES;
   localparam int FW   = (FMAX > 2) ? $clog2(FMAX) : 1;

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [FW-1:0] COIN_LAST = FW'(COIN_FRAMES - 1);
   localparam logic [FW-1:0] GAP_LAST  = FW'(GAP_FRAMES - 1);

   // Bit positions inside the combined {joy_p2, joy_p1} vector
   localparam int P2       = 9;
   localparam int B_RIGHT  = 0;
   localparam int B_LEFT   = 1;
   localparam int B_DOWN   = 2;
   localparam int B_UP     = 3;
   localparam int B_FIRE   = 4;
   localparam int B_BOMB   = 5;
   localparam int B_START1 = 6;
   localparam int B_START2 = 7;
   localparam int B_COIN   = 8;

   logic [17:0]   raw;
   logic [17:0]   deb_q;
   logic [17:0]   deb_d;
   logic [DW-1:0] cnt_q [18];
   logic [DW-1:0] cnt_d [18];

   assign raw = {joy_p2, joy_p1};

   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 18; i++) begin
         cnt_d[i] = '0;
         if (raw[i] != deb_q[i]) begin
            if (cnt_q[i] == DEB_LAST) begin
               deb_d[i] = ~deb_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         deb_q <= '0;
         cnt_q <= '{default: '0};
      end else begin
         deb_q <= deb_d;
         cnt_q <= cnt_d;
      end
   end

   logic vblank_q;
   logic frame_tick;
   logic coin_any;
   logic coin_any_q;
   logic coin_edge;

   assign frame_tick = vblank & ~vblank_q;
   assign coin_any   = deb_q[B_COIN] | deb_q[P2 + B_COIN];
   assign coin_edge  = coin_any & ~coin_any_q;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         vblank_q   <= 1'b0;
         coin_any_q <= 1'b0;
      end else begin
         vblank_q   <= vblank;
         coin_any_q <= coin_any;
      end
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2
   } coin_st_t;

   coin_st_t      state_q;
   coin_st_t      state_d;
   logic [FW-1:0] fcnt_q;
   logic [FW-1:0] fcnt_d;
   logic [1:0]    queue_q;
   logic [1:0]    queue_d;
   logic          enq;
   logic          deq;

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      deq     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (queue_q != 2'd0 && frame_tick) begin
               state_d = ST_PULSE;
               fcnt_d  = '0;
               deq     = 1'b1;
            end
         end
         ST_PULSE: begin
            if (frame_tick) begin
               if (fcnt_q == COIN_LAST) begin
                  state_d = ST_GAP;
                  fcnt_d  = '0;
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (frame_tick) begin
               if (fcnt_q == GAP_LAST) begin
                  state_d = ST_IDLE;
                  fcnt_d  = '0;
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            fcnt_d  = '0;
         end
      endcase

      // A press arriving with the queue full is lost; simultaneous enq/deq cancel out
      enq     = coin_edge && (queue_q != 2'd3);
      queue_d = queue_q;
      if (enq && !deq) begin
         queue_d = queue_q + 2'd1;
      end else if (deq && !enq) begin
         queue_d = queue_q - 2'd1;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         fcnt_q  <= '0;
         queue_q <= 2'd0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         queue_q <= queue_d;
      end
   end

   logic [1:0] fire_deb;
   logic [1:0] fire_lvl;

   assign fire_deb = {deb_q[P2 + B_FIRE], deb_q[B_FIRE]};

`ifdef INPUT_AUTOFIRE_EN
   localparam int AW = (AF_FRAMES > 2) ? $clog2(AF_FRAMES) : 1;
   localparam logic [AW-1:0] AF_LAST = AW'(AF_FRAMES - 1);

   logic [1:0]    af_act;
   logic [1:0]    af_phase_q;
   logic [1:0]    af_phase_d;
   logic [AW-1:0] af_cnt_q [2];
   logic [AW-1:0] af_cnt_d [2];

   assign af_act = fire_deb & {2{autofire_en}};

   // Phase 1 means "fire asserted"; it is held at 1 while idle so every press starts asserted
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         af_phase_d[p] = af_phase_q[p];
         af_cnt_d[p]   = af_cnt_q[p];
         if (!af_act[p]) begin
            af_phase_d[p] = 1'b1;
            af_cnt_d[p]   = '0;
         end else if (frame_tick) begin
            if (af_cnt_q[p] == AF_LAST) begin
               af_phase_d[p] = ~af_phase_q[p];
               af_cnt_d[p]   = '0;
            end else begin
               af_cnt_d[p] = af_cnt_q[p] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         af_phase_q <= 2'b11;
         af_cnt_q   <= '{default: '0};
      end else begin
         af_phase_q <= af_phase_d;
         af_cnt_q   <= af_cnt_d;
      end
   end

   assign fire_lvl = (af_act & af_phase_q) | (fire_deb & ~af_act);
`else
   logic unused_autofire;
   assign unused_autofire = autofire_en ^ (AF_FRAMES == 0);
   assign fire_lvl        = fire_deb;
`endif

   logic [1:0] o_coin_q;
   logic [1:0] o_fire_q;
   logic [1:0] o_bomb_q;
   logic [1:0] o_select_q;
   logic [1:0] o_up_q;
   logic [1:0] o_down_q;
   logic [1:0] o_left_q;
   logic [1:0] o_right_q;

   // Start buttons from either port share the select pair: bit0 start1, bit1 start2
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         o_coin_q   <= 2'b11;
         o_fire_q   <= 2'b11;
         o_bomb_q   <= 2'b11;
         o_select_q <= 2'b11;
         o_up_q     <= 2'b11;
         o_down_q   <= 2'b11;
         o_left_q   <= 2'b11;
         o_right_q  <= 2'b11;
      end else begin
         o_coin_q   <= {1'b1, (state_d != ST_PULSE)};
         o_fire_q   <= ~fire_lvl;
         o_bomb_q   <= ~{deb_q[P2 + B_BOMB], deb_q[B_BOMB]};
         o_select_q <= ~{deb_q[B_START2] | deb_q[P2 + B_START2],
                         deb_q[B_START1] | deb_q[P2 + B_START1]};
         o_up_q     <= ~{deb_q[P2 + B_UP], deb_q[B_UP]};
         o_down_q   <= ~{deb_q[P2 + B_DOWN], deb_q[B_DOWN]};
         o_left_q   <= ~{deb_q[P2 + B_LEFT], deb_q[B_LEFT]};
         o_right_q  <= ~{deb_q[P2 + B_RIGHT], deb_q[B_RIGHT]};
      end
   end

   assign o_coin   = o_coin_q;
   assign o_fire   = o_fire_q;
   assign o_bomb   = o_bomb_q;
   assign o_select = o_select_q;
   assign o_up     = o_up_q;
   assign o_down   = o_down_q;
   assign o_left   = o_left_q;
   assign o_right  = o_right_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner at DEB_CYCLES=16, COIN/GAP=4, AF=3.
`timescale 1ns/1ps
module tb_input_conditioner;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic       vblank;
   logic [8:0] joy_p1;
   logic [8:0] joy_p2;
   logic       autofire_en;
   logic [1:0] o_coin, o_fire, o_bomb, o_select, o_up, o_down, o_left, o_right;

   int n_tests = 0;
   int n_fail  = 0;

   input_conditioner #(
      .DEB_CYCLES (16),
      .COIN_FRAMES(4),
      .GAP_FRAMES (4),
      .AF_FRAMES  (3)
   ) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .vblank     (vblank),
      .joy_p1     (joy_p1),
      .joy_p2     (joy_p2),
      .autofire_en(autofire_en),
      .o_coin     (o_coin),
      .o_fire     (o_fire),
      .o_bomb     (o_bomb),
      .o_select   (o_select),
      .o_up       (o_up),
      .o_down     (o_down),
      .o_left     (o_left),
      .o_right    (o_right)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   // One 4-cycle frame; coin sampled on the tick edge, fire at the end of the frame
   task automatic frame(output logic c, output logic f);
      vblank = 1'b1;
      step(1);
      c = o_coin[0];
      vblank = 1'b0;
      step(3);
      f = o_fire[0];
   endtask

   task automatic coin_press(input logic use_p2);
      if (use_p2) joy_p2[8] = 1'b1; else joy_p1[8] = 1'b1;
      step(20);
      joy_p1[8] = 1'b0;
      joy_p2[8] = 1'b0;
      step(20);
   endtask

   task automatic run_frames(input int n, input logic prev_in,
                             output int lows, output int pulses, output int min_gap);
      logic prev, c, f, seen_low;
      int   hrun;
      prev = prev_in;
      seen_low = ~prev_in;
      hrun = 0;
      lows = 0;
      pulses = 0;
      min_gap = 999;
      for (int i = 0; i < n; i++) begin
         frame(c, f);
         if (!c) begin
            lows++;
            if (prev) begin
               if (seen_low && hrun < min_gap) min_gap = hrun;
               pulses++;
            end
            seen_low = 1'b1;
            hrun = 0;
         end else begin
            hrun++;
         end
         prev = c;
      end
   endtask

   initial begin
      logic       c, f;
      logic [8:0] fpat;
      logic [8:0] fexp;
      int         lows, pulses, gap;

      reset = 1'b1;
      vblank = 1'b0;
      joy_p1 = '0;
      joy_p2 = '0;
      autofire_en = 1'b0;

      #1;
      check("reset_outputs", {o_coin, o_fire, o_bomb, o_select, o_up, o_down, o_left, o_right},
            16'hFFFF);

      // Input held through reset: first change exactly 17 clocks after release
      joy_p1[0] = 1'b1;
      step(3);
      reset = 1'b0;
      step(16);
      check("post_reset_right_16", o_right, 2'b11);
      step(1);
      check("post_reset_right_17", o_right, 2'b10);
      joy_p1[0] = 1'b0;
      step(20);
      check("right_release", o_right, 2'b11);

      joy_p1[3] = 1'b1;
      step(16);
      check("up_16", o_up, 2'b11);
      step(1);
      check("up_17", o_up, 2'b10);
      joy_p1[3] = 1'b0;
      step(17);
      check("up_release", o_up, 2'b11);

      joy_p1[2] = 1'b1;
      step(15);
      joy_p1[2] = 1'b0;
      step(1);
      check("glitch15_a", o_down, 2'b11);
      step(20);
      check("glitch15_b", o_down, 2'b11);

      // 16-cycle pulse is just long enough to register
      joy_p1[1] = 1'b1;
      step(16);
      joy_p1[1] = 1'b0;
      step(1);
      check("pulse16_low", o_left, 2'b10);
      step(15);
      check("pulse16_hold", o_left, 2'b10);
      step(1);
      check("pulse16_back", o_left, 2'b11);

      joy_p2[5] = 1'b1;
      step(17);
      check("bomb_p2", o_bomb, 2'b01);
      joy_p2[5] = 1'b0;
      joy_p1[6] = 1'b1;
      step(17);
      check("select_start1", o_select, 2'b10);
      check("bomb_p2_release", o_bomb, 2'b11);
      joy_p1[6] = 1'b0;
      joy_p1[7] = 1'b1;
      step(17);
      check("select_start2", o_select, 2'b01);
      joy_p1[7] = 1'b0;
      step(17);
      check("select_release", o_select, 2'b11);

      joy_p1[4] = 1'b1;
      autofire_en = 1'b1;
      step(17);
      check("fire_first", o_fire, 2'b10);
      fpat = '0;
      for (int i = 0; i < 9; i++) begin
         frame(c, f);
         fpat[i] = f;
      end
`ifdef INPUT_AUTOFIRE_EN
      fexp = 9'b100011100;
`else
      fexp = 9'b000000000;
`endif
      check("fire_pattern", fpat, fexp);
      joy_p1[4] = 1'b0;
      autofire_en = 1'b0;
      step(20);
      check("fire_release", o_fire, 2'b11);

      coin_press(1'b0);
      check("coin_idle", o_coin, 2'b11);
      run_frames(12, 1'b1, lows, pulses, gap);
      check("single_coin_lows", lows, 4);
      check("single_coin_pulses", pulses, 1);

      for (int i = 0; i < 5; i++) coin_press(i[0]);
      run_frames(30, 1'b1, lows, pulses, gap);
      check("five_coin_pulses", pulses, 3);
      check("five_coin_lows", lows, 12);
      check("five_coin_gap_ge4", (gap >= 4) ? 1 : 0, 1);
      check("coin_bit1_high", o_coin[1], 1'b1);

      // Coin edge lands on the same clock as the dequeue of the only queued coin
      coin_press(1'b0);
      joy_p1[8] = 1'b1;
      step(16);
      vblank = 1'b1;
      step(1);
      vblank = 1'b0;
      check("coincident_pulse_start", o_coin, 2'b10);
      joy_p1[8] = 1'b0;
      step(3);
      run_frames(20, 1'b0, lows, pulses, gap);
      check("coincident_more_pulses", pulses, 1);
      check("coincident_lows", lows, 7);

      for (int i = 0; i < 3; i++) coin_press(1'b0);
      frame(c, f);
      check("pre_reset_pulse", c, 1'b0);
      #1;
      reset = 1'b1;
      #1;
      check("async_reset_coin", o_coin, 2'b11);
      check("async_reset_all", {o_coin, o_fire, o_bomb, o_select, o_up, o_down, o_left, o_right},
            16'hFFFF);
      step(2);
      reset = 1'b0;
      run_frames(20, 1'b1, lows, pulses, gap);
      check("after_reset_no_pulse", pulses, 0);
      check("after_reset_coin_high", o_coin, 2'b11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1024: consecutive clk_sys cycles an input must differ from its debounced level before the level changes.
REQ-002 SHALL have parameter COIN_FRAMES, default 4: coin pulse length in VBlank rising edges.
REQ-003 SHALL have parameter GAP_FRAMES, default 4: minimum released frames between coin pulses.
REQ-004 SHALL have parameter AF_FRAMES, default 3: autofire half-period in VBlank rising edges.
REQ-005 SHALL have port clk_sys, input, 1: the single clock.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port vblank, input, 1: frame timebase, synchronous to clk_sys.
REQ-008 SHALL have port joy_p1, input, 9, active-high: [8] coin, [7] start2, [6] start1, [5] bomb, [4] fire, [3] up, [2] down, [1] left, [0] right.
REQ-009 SHALL have port joy_p2, input, 9: player 2, with the same layout as joy_p1.
REQ-010 SHALL have port autofire_en, input, 1: autofire request.
REQ-011 SHALL have outputs o_coin, o_fire, o_bomb, o_select, o_up, o_down, o_left and o_right, each output, 2, active-low; bit0 is player 1 and bit1 is player 2 (start2 for o_select).

Function
REQ-012 SHALL debounce all 18 input bits independently, using one counter per bit.
REQ-013 SHALL clear a bit's counter on any cycle where the raw input equals the debounced level.
REQ-014 SHALL invert the debounced level, and clear the counter, on the cycle a bit's counter reaches DEB_CYCLES-1.
REQ-015 SHALL produce a direction, bomb or start output change exactly DEB_CYCLES+1 clocks after a stable input change.
REQ-016 SHALL ignore glitches shorter than DEB_CYCLES cycles, with no output change.
REQ-017 SHALL drive o_up/down/left/right/bomb/select as the registered inversion of the debounced levels.
REQ-018 SHALL detect a frame tick as a one-cycle pulse on each vblank 0->1 transition.
REQ-019 SHALL form coin_edge as the rising edge of the OR of the two debounced coin bits.
REQ-020 SHALL keep a coin queue counter of 2 bits, saturating at 3.
REQ-021 SHALL drop a coin_edge that arrives while the queue holds 3.
REQ-022 SHALL run a coin FSM with states IDLE, PULSE and GAP.
REQ-023 SHALL move IDLE->PULSE on the cycle the queue is non-zero and a frame tick occurs, decrementing the queue on that cycle.
REQ-024 SHALL move PULSE->GAP after COIN_FRAMES frame ticks.
REQ-025 SHALL move GAP->IDLE after GAP_FRAMES frame ticks.
REQ-026 SHALL leave the queue count unchanged when an enqueue and a dequeue occur in the same cycle.
REQ-027 SHALL drive o_coin[0]=0 only in PULSE, and SHALL hold o_coin[1]=1 at all times.
REQ-028 SHALL, without autofire, drive o_fire as the registered inversion of the debounced fire bits.

Reset
REQ-029 SHALL, on reset assertion, immediately force all outputs to 2'b11.
REQ-030 SHALL, on reset, force all debounced levels to 0, all counters to 0, the queue to 0, the FSM to IDLE and the frame-tick history to 0.
REQ-031 SHALL, on reset mid-pulse, abort the pulse and discard queued coins.
REQ-032 SHALL produce no output change earlier than DEB_CYCLES+1 clocks after reset deassertion.

Configuration
REQ-033 SHALL compile the autofire logic only when macro INPUT_AUTOFIRE_EN is defined.
REQ-034 SHALL, with INPUT_AUTOFIRE_EN defined, while a player's debounced fire and autofire_en are both 1, assert that o_fire bit on the first cycle and then toggle it every AF_FRAMES frame ticks.
REQ-035 SHALL, with INPUT_AUTOFIRE_EN defined, restart the autofire phase (asserted) on every fire press.
REQ-036 SHALL, with INPUT_AUTOFIRE_EN defined, make o_fire follow REQ-028 when autofire_en=0.
REQ-037 SHALL, without INPUT_AUTOFIRE_EN, ignore autofire_en and apply REQ-028.

Verification
REQ-038 SHALL cover: joy_p1[3]=1 held at DEB_CYCLES=16 -> o_up[0] falls exactly 17 clocks later; a 15-cycle pulse -> no change.
REQ-039 SHALL cover: single coin press, then 12 vblank edges -> o_coin[0] low for exactly 4 frame ticks, once.
REQ-040 SHALL cover: 5 coin presses within one frame (with debounce satisfied) -> exactly 3 pulses, each separated by at least 4 high frames.
REQ-041 SHALL cover: coin_edge coincident with a dequeue at queue=1 -> queue stays 1 and 2 total pulses are produced.
REQ-042 SHALL cover: reset asserted during PULSE with queue=2 -> o_coin=2'b11 asynchronously and no further pulses after release.
REQ-043 SHALL cover, with INPUT_AUTOFIRE_EN defined: fire held with autofire_en=1 and AF_FRAMES=3 -> o_fire[0] pattern low 3 / high 3 frames; with the macro undefined -> held low.
